// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and defaults for the FIFO read controller
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } state_e;

  // One skid-buffer slot: a FIFO word plus its end-of-burst tag.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } entry_t;

endpackage

// File: rtl/fifo_reader_if.sv
// rtl/fifo_reader_if.sv - FIFO read port and downstream stream bundle
interface fifo_reader_if #(
  parameter int DATA_W = fifo_pkg::DEF_DATA_W,
  parameter int CNT_W  = fifo_pkg::DEF_CNT_W
);

  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_data;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    input  fifo_cnt, fifo_data, m_ready,
    output fifo_rd, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_cnt, fifo_data, m_ready,
    input  fifo_rd, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// rtl/fifo_reader_skid.sv - two-entry skid buffer with registered head
module fifo_reader_skid
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output logic [1:0] occupancy,
  output logic       head_valid,
  output entry_t     head
);

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic       pop_ok;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    pop_ok = pop && (occ_q != 2'd0);
    case ({push, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_entry;
        else               tail_d = push_entry;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop: the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = push_entry;
        end else begin
          head_d = tail_q;
          tail_d = push_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occupancy  = occ_q;
  assign head_valid = (occ_q != 2'd0);
  assign head       = head_q;

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read controller with streaming and burst modes
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic burst_en,
  fifo_reader_if.master io
);

  localparam int               TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(BURST);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               burst_q, burst_d;
  logic               inflight_q, inflight_d;
  logic               inflight_last_q, inflight_last_d;
  logic               rd_req;

  logic [DATA_W-1:0]  rd_word;
  logic [1:0]         occ;
  logic               head_valid;
  entry_t             head;
  entry_t             push_entry;
  logic               pop;
  logic               cnt_nz;
  logic [2:0]         slots;
  logic               room;

  assign rd_word    = io.fifo_data;
  assign cnt_nz     = (io.fifo_cnt != '0);
  assign pop        = head_valid && io.m_ready;
  assign push_entry = '{data: rd_word, last: inflight_last_q};

  // A word already requested still needs a slot, so it counts against the buffer.
  assign slots = {1'b0, occ} + {2'b00, inflight_q};
  assign room  = slots < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    rem_d           = rem_q;
    burst_d         = burst_q;
    rd_req          = 1'b0;
    inflight_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_nz) begin
          burst_d = burst_en;
          timer_d = '0;
          state_d = burst_en ? WAIT : DRAIN;
        end
      end
      WAIT: begin
        if (timer_q != TMR_LAST) timer_d = timer_q + 1'b1;
        if (io.fifo_cnt >= BURST_C) begin
          state_d = DRAIN;
          rem_d   = BURST_C;
        end else if (timer_q == TMR_LAST) begin
          state_d = cnt_nz ? DRAIN : IDLE;
          rem_d   = io.fifo_cnt;
        end
      end
      DRAIN: begin
        rd_req = cnt_nz && room && (!burst_q || (rem_q != '0));
        if (rd_req && burst_q) begin
          rem_d           = rem_q - 1'b1;
          inflight_last_d = (rem_q == CNT_W'(1));
        end
        if (burst_q) begin
          if (pop && head.last) state_d = IDLE;
        end else if (!cnt_nz && !inflight_q && (occ == 2'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = rd_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      rem_q           <= '0;
      burst_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      rem_q           <= rem_d;
      burst_q         <= burst_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  fifo_reader_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_entry (push_entry),
    .pop        (pop),
    .occupancy  (occ),
    .head_valid (head_valid),
    .head       (head)
  );

  assign io.fifo_rd = rd_req;
  assign io.m_valid = head_valid;
  assign io.m_data  = head.data;
  assign io.m_last  = head.last;

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the team's synchronous FIFO. It pops words through the FIFO's `rd` / `fifo_cnt` / `data_out` interface, absorbs the FIFO's one-cycle read latency, and presents the words downstream on a valid/ready stream. It has two modes:
- Streaming: drain continuously.
- Burst: collect words up to a threshold or timeout, then emit them as a burst with a last marker.

## Interface
- `DATA_W`, 8, FIFO word width
- `CNT_W`, 4, width of FIFO occupancy count (FIFO depth 8)
- `BURST`, 4, burst length in burst mode (1..8)
- `TIMEOUT`, 16, cycles to wait in burst mode before emitting a partial burst (≥2)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `burst_en`  in  1  1 = burst mode, 0 = streaming; sampled only in IDLE
- `fifo_cnt`  in  CNT_W  FIFO occupancy
- `fifo_rd`  out  1  pop request to FIFO
- `fifo_data`  in  DATA_W  FIFO `data_out`; valid the cycle after an edge that sampled `fifo_rd`=1
- `m_valid`  out  1  output word valid
- `m_data`  out  DATA_W  output word
- `m_last`  out  1  final word of a burst (always 0 in streaming)
- `m_ready`  in  1  downstream accept; transfer when `m_valid`&&`m_ready`

## Operation
- Reset values: `fifo_rd`=0, `m_valid`=0, `m_data`=0, `m_last`=0. State is IDLE; timer, remaining-count, in-flight flag and skid buffer are cleared.
- Output path: 2-entry skid buffer. `fifo_rd` is combinational and is asserted only when all of the following hold:
  - `fifo_cnt`≠0
  - the state permits reads
  - `occupancy + inflight − pop_this_cycle < 2`
- The buffer never overflows, and no word is dropped under backpressure.
- States:
  - IDLE: no reads. If `fifo_cnt`≠0: go to DRAIN if `burst_en`=0, else go to WAIT with timer=0.
  - WAIT (burst only): timer increments each cycle.
    - If `fifo_cnt`≥BURST: go to DRAIN with rem=BURST.
    - Else if timer==TIMEOUT−1: go to DRAIN with rem=`fifo_cnt`.
    - Threshold wins over timeout if both occur in the same cycle.
  - DRAIN, streaming: read whenever allowed. Return to IDLE when `fifo_cnt`==0, nothing is in flight, and the buffer is empty.
  - DRAIN, burst: each issued read decrements rem, and the read taking rem to 0 is tagged last. Return to IDLE once the last-tagged word has transferred.
- The last tag travels with its word through the buffer; `m_last` reflects the head entry.
- Reads are issued only when `fifo_cnt`≠0, so a FIFO underflow is never requested. Concurrent FIFO writes are invisible except through `fifo_cnt`.
- A `burst_en` change mid-burst or mid-stream takes effect at the next IDLE.
- Reset mid-operation: state and buffer are cleared immediately (asynchronously). A word in flight from the FIFO is discarded and counts as consumed.

## Timing
- Read latency: if `fifo_rd` is sampled at edge N, the word is loaded into the buffer at edge N+1, and `m_valid`=1 from edge N+1 when the buffer was empty.
- Throughput: with `m_ready`=1 and `fifo_cnt`≠0, one `fifo_rd` per cycle and one transfer per cycle in steady state.
- `m_valid`, `m_data`, `m_last` are registered (buffer head). They stay stable while `m_valid`&&!`m_ready`.
- `fifo_cnt` lag: the FIFO decrements at the same edge that samples `fifo_rd`, so the combinational gating on current `fifo_cnt` is exact.
- Timer width is `$clog2(TIMEOUT)`, saturating, never wraps. rem width is CNT_W.

## Structure
- Shared package `fifo_pkg`: state enum {IDLE, WAIT, DRAIN}, default `DATA_W`/`CNT_W` constants, and a buffer-entry struct {data, last}.
- One sub-module, `fifo_reader_skid`: the 2-entry skid buffer. It exposes occupancy, push (data+last), pop, and head outputs.
- The top level holds the FSM, timer, rem counter, in-flight flag and `fifo_rd` gating.

## Test plan
- Reset: assert `rst`=0 mid-cycle. Require all outputs 0 asynchronously; `fifo_rd` stays 0 while `fifo_cnt`=0.
- Streaming: `burst_en`=0, preload 8 words 0,5,…,35, `m_ready`=1. Require:
  - `fifo_rd` high for 8 consecutive cycles
  - `m_data` 0..35 in order on 8 consecutive cycles, starting one edge after the first `fifo_rd`
  - `m_last`=0 throughout
- Backpressure: same preload, `m_ready`=0. Require exactly 2 pops (`fifo_cnt` 8→6) and `m_data`=0 held. Then raise `m_ready`; require 0..35 with no loss or duplicate.
- Burst threshold: `burst_en`=1, write 4 words 1,2,3,4. Require transfers 1,2,3,4 with `m_last`=1 only on 4, then return to IDLE.
- Burst timeout: `burst_en`=1, write 2 words 9,10, no more writes. Require no `fifo_rd` for 16 cycles, then 9,10 with `m_last` on 10.
- Reset mid-burst: pulse `rst` low during the DRAIN of a 4-word burst after 2 transfers. Require outputs cleared and no `fifo_rd` during reset. After release, a fresh burst starts from the remaining `fifo_cnt` content.
